// File: rtl/inference_sequencer_pkg.sv
// Shared types and defaults for the inference sequencer and its loaders.
// Holds the controller state encoding, the error code encoding and the
// default word-per-load and wait-timeout values.
package inference_sequencer_pkg;

  localparam int DEF_WORDS_PER_LOAD = 8;
  localparam int DEF_TIMEOUT        = 1023;
  localparam int DATA_W             = 64;
  localparam int ROWS_W             = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_LOAD,
    ST_W_WAIT,
    ST_X_LOAD,
    ST_X_WAIT,
    ST_RUN,
    ST_ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_BAD_CMD   = 2'd1,
    ERR_OCCUPANCY = 2'd2,
    ERR_TIMEOUT   = 2'd3
  } err_t;

endpackage

// File: rtl/inference_sequencer_if.sv
// Bundle of command, weight/input streams, accelerator control and status.
// The master modport is the sequencer side; slave is the surrounding system
// (command source, word sources and the accelerator itself).
interface inference_sequencer_if;
  import inference_sequencer_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ROWS_W-1:0] cmd_rows;
  logic              cmd_reload;

  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;

  logic              x_valid;
  logic              x_ready;
  logic [DATA_W-1:0] x_data;

  logic              load_weights;
  logic              start_inference;
  logic              weight_write_en;
  logic              input_write_en;
  logic [DATA_W-1:0] weight_reg;
  logic [DATA_W-1:0] input_reg;

  logic              controller_busy;
  logic              weights_done;
  logic              inputs_done;
  logic              systolic_done;
  logic              occupancy_err;

  logic              job_done;
  logic              job_err;
  logic              busy;
  logic [1:0]        err_code;

  modport master (
    input  cmd_valid, cmd_rows, cmd_reload,
    input  w_valid, w_data, x_valid, x_data,
    input  controller_busy, weights_done, inputs_done, systolic_done, occupancy_err,
    output cmd_ready, w_ready, x_ready,
    output load_weights, start_inference, weight_write_en, input_write_en,
    output weight_reg, input_reg,
    output job_done, job_err, busy, err_code
  );

  modport slave (
    output cmd_valid, cmd_rows, cmd_reload,
    output w_valid, w_data, x_valid, x_data,
    output controller_busy, weights_done, inputs_done, systolic_done, occupancy_err,
    input  cmd_ready, w_ready, x_ready,
    input  load_weights, start_inference, weight_write_en, input_write_en,
    input  weight_reg, input_reg,
    input  job_done, job_err, busy, err_code
  );

endinterface

// File: rtl/inference_sequencer_stream_loader.sv
// Count-limited valid/ready to register+write-enable converter for one word stream.
// Latency: accepted word appears on wr_data with wr_en high the cycle after the handshake.
// Backpressure: in_ready only while enabled and the accelerator is not stalling.
module stream_loader
  import inference_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ROWS_W-1:0] target,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              last
);

  logic [ROWS_W-1:0] count;
  logic              fire;

  assign in_ready = en && !stall;
  assign fire     = in_valid && in_ready;
  // target is never zero here, so target-1 is the index of the final word
  assign last     = fire && (count == target - ROWS_W'(1));

  // words accepted so far; held at zero whenever the loader is not active
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!en) begin
      count <= '0;
    end else if (fire) begin
      count <= count + ROWS_W'(1);
    end
  end

  // capture each accepted word and strobe its write enable for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_data <= '0;
    end else begin
      wr_en <= fire;
      if (fire) begin
        wr_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/inference_sequencer.sv
// Job sequencer: loads weights (optional) and inputs into the accelerator, starts it, reports done/error.
// Latency: strobes (load_weights, start_inference, job_done, write enables) lag their cause by one cycle.
// Backpressure: one command at a time (cmd_ready only when idle); stream ready drops while controller_busy.
module inference_sequencer
  import inference_sequencer_pkg::*;
#(
  parameter int WORDS_PER_LOAD = DEF_WORDS_PER_LOAD,
  parameter int TIMEOUT        = DEF_TIMEOUT
) (
  input logic clk,
  input logic rst,
  inference_sequencer_if.master bus
);

  localparam int                WAIT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [ROWS_W-1:0] W_TARGET = ROWS_W'(WORDS_PER_LOAD);

  state_t            state, state_nxt;
  err_t              err_q, err_nxt;
  logic [ROWS_W-1:0] rows_q;
  logic              weights_valid;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting, timed_out, fault_watch;
  logic              w_en, x_en, w_last, x_last;
  logic              lw_q, si_q, jd_q;

  assign w_en        = (state == ST_W_LOAD);
  assign x_en        = (state == ST_X_LOAD);
  assign waiting     = (state == ST_W_WAIT) || (state == ST_X_WAIT) || (state == ST_RUN);
  assign timed_out   = (wait_cnt == WAIT_W'(TIMEOUT));
  // ERR always returns to IDLE after its single cycle, so it is not watched for faults
  assign fault_watch = (state != ST_IDLE) && (state != ST_ERR);

  stream_loader u_w_loader (
    .clk      (clk),
    .rst      (rst),
    .en       (w_en),
    .target   (W_TARGET),
    .stall    (bus.controller_busy),
    .in_valid (bus.w_valid),
    .in_ready (bus.w_ready),
    .in_data  (bus.w_data),
    .wr_en    (bus.weight_write_en),
    .wr_data  (bus.weight_reg),
    .last     (w_last)
  );

  stream_loader u_x_loader (
    .clk      (clk),
    .rst      (rst),
    .en       (x_en),
    .target   (rows_q),
    .stall    (bus.controller_busy),
    .in_valid (bus.x_valid),
    .in_ready (bus.x_ready),
    .in_data  (bus.x_data),
    .wr_en    (bus.input_write_en),
    .wr_data  (bus.input_reg),
    .last     (x_last)
  );

  // next state and error code; done inputs beat a same-cycle timeout, occupancy faults beat both
  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          err_nxt = ERR_NONE;
          if (bus.cmd_rows == '0) begin
            state_nxt = ST_ERR;
            err_nxt   = ERR_BAD_CMD;
          end else if (bus.cmd_reload) begin
            state_nxt = ST_W_LOAD;
          end else if (weights_valid) begin
            state_nxt = ST_X_LOAD;
          end else begin
            state_nxt = ST_ERR;
            err_nxt   = ERR_BAD_CMD;
          end
        end
      end
      ST_W_LOAD: if (w_last) state_nxt = ST_W_WAIT;
      ST_W_WAIT: begin
        if (bus.weights_done) begin
          state_nxt = ST_X_LOAD;
        end else if (timed_out) begin
          state_nxt = ST_ERR;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      ST_X_LOAD: if (x_last) state_nxt = ST_X_WAIT;
      ST_X_WAIT: begin
        if (bus.inputs_done) begin
          state_nxt = ST_RUN;
        end else if (timed_out) begin
          state_nxt = ST_ERR;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      ST_RUN: begin
        if (bus.systolic_done) begin
          state_nxt = ST_IDLE;
        end else if (timed_out) begin
          state_nxt = ST_ERR;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (fault_watch && bus.occupancy_err) begin
      state_nxt = ST_ERR;
      err_nxt   = ERR_OCCUPANCY;
    end
  end

  // state and sticky error code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      err_q <= ERR_NONE;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
    end
  end

  // job bookkeeping: latched row count, weight validity and the per-state wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_q        <= '0;
      weights_valid <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      if ((state == ST_IDLE) && bus.cmd_valid) begin
        rows_q <= bus.cmd_rows;
      end
      if ((state == ST_W_WAIT) && (state_nxt == ST_X_LOAD)) begin
        weights_valid <= 1'b1;
      end else if (state == ST_ERR) begin
        weights_valid <= 1'b0;
      end
      if (state_nxt != state) begin
        wait_cnt <= '0;
      end else if (waiting) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  // one-cycle strobes on entry to W_LOAD, entry to RUN and successful completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lw_q <= 1'b0;
      si_q <= 1'b0;
      jd_q <= 1'b0;
    end else begin
      lw_q <= (state == ST_IDLE)   && (state_nxt == ST_W_LOAD);
      si_q <= (state == ST_X_WAIT) && (state_nxt == ST_RUN);
      jd_q <= (state == ST_RUN)    && (state_nxt == ST_IDLE);
    end
  end

  assign bus.cmd_ready       = (state == ST_IDLE);
  assign bus.busy            = (state != ST_IDLE);
  assign bus.job_err         = (state == ST_ERR);
  assign bus.err_code        = err_q;
  assign bus.load_weights    = lw_q;
  assign bus.start_inference = si_q;
  assign bus.job_done        = jd_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Randomised job-level bench for inference_sequencer.
// Expected strobe counts, data and error codes come from a job-level model
// (weights-valid flag plus per-command outcome rules).
module tb_inference_sequencer;

  localparam int WPL = 8;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inference_sequencer_if bus ();

  inference_sequencer #(.WORDS_PER_LOAD(WPL), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // monitor-owned observation state
  int cyc = 0, n_lw = 0, n_wwe = 0, n_xwe = 0, n_si = 0, n_jd = 0, n_je = 0;
  int si_cyc = 0, je_cyc = 0;
  logic [63:0] got_w[$];
  logic [63:0] got_x[$];

  // driver-owned expectations
  logic [63:0] exp_w[$];
  logic [63:0] exp_x[$];
  bit m_wv = 0;
  int gw = 0, ew = 0, gx = 0, ex = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.load_weights)    n_lw  <= n_lw + 1;
    if (bus.start_inference) begin n_si <= n_si + 1; si_cyc <= cyc; end
    if (bus.job_done)        n_jd  <= n_jd + 1;
    if (bus.job_err)         begin n_je <= n_je + 1; je_cyc <= cyc; end
    if (bus.weight_write_en) begin n_wwe <= n_wwe + 1; got_w.push_back(bus.weight_reg); end
    if (bus.input_write_en)  begin n_xwe <= n_xwe + 1; got_x.push_back(bus.input_reg); end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.cmd_valid = 0; bus.cmd_rows = '0; bus.cmd_reload = 0;
    bus.w_valid = 0; bus.w_data = '0; bus.x_valid = 0; bus.x_data = '0;
    bus.controller_busy = 0; bus.weights_done = 0; bus.inputs_done = 0;
    bus.systolic_done = 0; bus.occupancy_err = 0;
  endtask

  task automatic send_cmd(input bit reload, input int rows);
    int g = 0;
    tick();
    bus.cmd_valid = 1; bus.cmd_reload = reload; bus.cmd_rows = 8'(rows);
    @(negedge clk);
    while (!bus.cmd_ready && g < 50) begin @(negedge clk); g++; end
    if (!bus.cmd_ready) chk("cmd_accept", 64'(bus.cmd_ready), 64'(1));
    tick();
    bus.cmd_valid = 0;
  endtask

  // push n words on one stream with random valid gaps, busy stalls and stray done inputs
  task automatic feed(input bit is_x, input int n, input bit stray);
    int sent = 0;
    int guard = 0;
    logic [63:0] d = {$urandom, $urandom};
    while (sent < n && guard < 2000) begin
      tick();
      bus.controller_busy = ($urandom_range(0, 3) == 0);
      if (is_x) begin bus.x_valid = ($urandom_range(0, 3) != 0); bus.x_data = d; end
      else      begin bus.w_valid = ($urandom_range(0, 3) != 0); bus.w_data = d; end
      if (stray) begin
        bus.weights_done  = ($urandom_range(0, 4) == 0);
        bus.inputs_done   = ($urandom_range(0, 4) == 0);
        bus.systolic_done = ($urandom_range(0, 4) == 0);
      end
      @(negedge clk);
      chk("ready_vs_busy", 64'((bus.w_ready | bus.x_ready) & bus.controller_busy), 64'(0));
      chk("other_ready", 64'(is_x ? bus.w_ready : bus.x_ready), 64'(0));
      if (is_x ? (bus.x_valid && bus.x_ready) : (bus.w_valid && bus.w_ready)) begin
        if (is_x) exp_x.push_back(d); else exp_w.push_back(d);
        sent++;
        d = {$urandom, $urandom};
      end
      guard++;
    end
    if (sent < n) chk("feed_budget", 64'(sent), 64'(n));
    tick();
    bus.w_valid = 0; bus.x_valid = 0; bus.controller_busy = 0;
    bus.weights_done = 0; bus.inputs_done = 0; bus.systolic_done = 0;
  endtask

  task automatic pulse_done(input int which);
    repeat ($urandom_range(0, 3)) tick();
    tick();
    case (which)
      0:       bus.weights_done  = 1;
      1:       bus.inputs_done   = 1;
      default: bus.systolic_done = 1;
    endcase
    tick();
    bus.weights_done = 0; bus.inputs_done = 0; bus.systolic_done = 0;
  endtask

  task automatic wait_end(input int jd0, input int je0);
    int g = 0;
    do begin @(negedge clk); #1; g++; end while (n_jd == jd0 && n_je == je0 && g < 100);
    if (n_jd == jd0 && n_je == je0) chk("job_end_budget", 64'(g), 64'(0));
  endtask

  task automatic cmp_data();
    chk("w_words", 64'(got_w.size() - gw), 64'(exp_w.size() - ew));
    chk("x_words", 64'(got_x.size() - gx), 64'(exp_x.size() - ex));
    while (gw < got_w.size() && ew < exp_w.size()) begin chk("w_data", got_w[gw], exp_w[ew]); gw++; ew++; end
    while (gx < got_x.size() && ex < exp_x.size()) begin chk("x_data", got_x[gx], exp_x[ex]); gx++; ex++; end
    gw = got_w.size(); ew = exp_w.size(); gx = got_x.size(); ex = exp_x.size();
  endtask

  // mode 0: normal, 1: occupancy fault mid input load, 2: systolic_done withheld
  task automatic run_job(input bit reload, input int rows, input int mode);
    int lw0 = n_lw, ww0 = n_wwe, xw0 = n_xwe, si0 = n_si, jd0 = n_jd, je0 = n_je;
    bit bad  = (rows == 0) || (!reload && !m_wv);
    int k    = (mode == 1) ? rows / 2 : rows;
    int e_lw = (!bad && reload) ? 1 : 0;
    int e_ww = e_lw * WPL;
    int e_xw = bad ? 0 : k;
    int e_si = (!bad && mode != 1) ? 1 : 0;
    int e_jd = (!bad && mode == 0) ? 1 : 0;
    int e_cd = bad ? 1 : (mode == 1) ? 2 : (mode == 2) ? 3 : 0;
    send_cmd(reload, rows);
    if (!bad) begin
      if (reload) begin feed(0, WPL, 1); pulse_done(0); end
      feed(1, k, 1);
      if (mode == 1) begin
        tick(); bus.occupancy_err = 1; bus.inputs_done = 1;
        tick(); bus.occupancy_err = 0; bus.inputs_done = 0;
      end else begin
        pulse_done(1);
        if (mode == 0) pulse_done(2);
      end
    end
    wait_end(jd0, je0);
    chk("err_code", 64'(bus.err_code), 64'(e_cd));
    chk("load_weights", 64'(n_lw - lw0), 64'(e_lw));
    chk("weight_writes", 64'(n_wwe - ww0), 64'(e_ww));
    chk("input_writes", 64'(n_xwe - xw0), 64'(e_xw));
    chk("start_inference", 64'(n_si - si0), 64'(e_si));
    chk("job_done", 64'(n_jd - jd0), 64'(e_jd));
    chk("job_err", 64'(n_je - je0), 64'(1 - e_jd));
    if (!bad && mode == 2) chk("timeout_cycles", 64'(je_cyc - si_cyc), 64'(TMO + 1));
    cmp_data();
    m_wv = (!bad && mode == 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
    chk({tag, "_readies"}, 64'({bus.w_ready, bus.x_ready}), 64'(0));
    chk({tag, "_strobes"}, 64'({bus.load_weights, bus.start_inference, bus.weight_write_en,
                                 bus.input_write_en, bus.job_done, bus.job_err}), 64'(0));
    chk({tag, "_err_code"}, 64'(bus.err_code), 64'(0));
    chk({tag, "_weight_reg"}, bus.weight_reg, 64'(0));
    chk({tag, "_input_reg"}, bus.input_reg, 64'(0));
  endtask

  task automatic pulse_rst();
    tick(); rst = 1;
    tick(); tick(); rst = 0;
    m_wv = 0;
    gw = got_w.size(); ew = exp_w.size(); gx = got_x.size(); ex = exp_x.size();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    tick(); rst = 0;

    // reload with 4 rows, then reuse weights with 2 rows and with the full 255 rows
    run_job(1, 4, 0);
    run_job(0, 2, 0);
    run_job(0, 255, 0);

    // zero rows is rejected, and the error code stays until the next command
    run_job(1, 0, 0);
    repeat (3) @(negedge clk);
    chk("err_code_hold", 64'(bus.err_code), 64'(1));

    // weights loaded, then reset: reuse must be refused
    run_job(1, 2, 0);
    pulse_rst();
    run_job(0, 3, 0);

    // occupancy fault with simultaneous inputs_done, then reuse is refused
    run_job(1, 3, 1);
    run_job(0, 2, 0);

    // RUN timeout
    run_job(1, 3, 2);

    // reset in the middle of a weight load with the accelerator stalling
    send_cmd(1, 4);
    feed(0, 3, 0);
    bus.controller_busy = 1;
    bus.w_valid = 1;
    #2 rst = 1;
    #1;
    chk_reset_outputs("mid_rst");
    tick(); tick();
    clear_inputs();
    rst = 0;
    m_wv = 0;
    gw = got_w.size(); ew = exp_w.size(); gx = got_x.size(); ex = exp_x.size();
    run_job(0, 3, 0);

    // random jobs
    for (int j = 0; j < 30; j++) begin
      int r = $urandom_range(0, 9);
      int mode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      bit reload = ($urandom_range(0, 2) == 0) || !m_wv;
      int rows = ($urandom_range(0, 12) == 0) ? 0 : $urandom_range(1, 12);
      if ($urandom_range(0, 7) == 0) reload = 0;
      run_job(reload, rows, mode);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
